// File: rtl/alu_issue_ctrl_if.sv
// Bundle of request, response and external-ALU signals for alu_issue_ctrl.
// The slave modport is the controller side; the master modport is the environment side.
interface alu_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] req_func;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_func;
  logic [7:0] alu_c;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_c;
  logic       rsp_err;

  logic [2:0] fifo_count;

  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready, alu_c,
    output req_ready, rsp_valid, rsp_c, rsp_err, alu_a, alu_b, alu_func, fifo_count
  );

  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready, alu_c,
    input  req_ready, rsp_valid, rsp_c, rsp_err, alu_a, alu_b, alu_func, fifo_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Queues ALU requests in a small FIFO, issues one at a time to an external
// combinational ALU and holds each result until the consumer takes it.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] func;
  } op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  op_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]   count;
  op_t          opr;
  logic [7:0]   rsp_c_q;
  logic         rsp_err_q;
  state_t       state, nstate;
  logic         push, pop;

  assign bus.req_ready  = (count < 3'(DEPTH));
  assign push           = bus.req_valid && bus.req_ready;
  assign bus.alu_a      = opr.a;
  assign bus.alu_b      = opr.b;
  assign bus.alu_func   = opr.func;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.fifo_count = count;

  // Pops only look at entries already stored; a same-edge push is never bypassed.
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    case (state)
      IDLE: if (count != 3'd0) begin
        pop    = 1'b1;
        nstate = ISSUE;
      end
      ISSUE: nstate = RESP;
      RESP: if (bus.rsp_ready) begin
        if (count != 3'd0) begin
          pop    = 1'b1;
          nstate = ISSUE;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.req_a, b: bus.req_b, func: bus.req_func};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opr       <= '0;
      rsp_c_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (pop) opr <= mem[rd_ptr];
      if (state == ISSUE) begin
        rsp_c_q   <= bus.alu_c;
        rsp_err_q <= (opr.func == 3'b111);
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table plus corner-case
// sequences, results checked in order against a scoreboard queue.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment-side ALU; opcode 111 yields zero.
  always_comb begin
    case (bus.alu_func)
      3'b000:  bus.alu_c = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_c = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_c = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_c = bus.alu_a ^ bus.alu_b;
      3'b100:  bus.alu_c = ~bus.alu_a;
      3'b101:  bus.alu_c = bus.alu_a << bus.alu_b;
      3'b110:  bus.alu_c = bus.alu_a >> bus.alu_b;
      default: bus.alu_c = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [7:0] c;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  bit   gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Scoreboard: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_rsp: got rsp_c=%0h with no pending request", bus.rsp_c);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_c", 32'(bus.rsp_c), 32'(e.c));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
      if (gap_en && last_cyc >= 0) chk("rsp_gap", 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                      input logic [7:0] c, input logic err);
    exp_t e;
    int   n;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_func  = f;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    end else begin
      @(posedge clk);
      e.c   = c;
      e.err = err;
      q.push_back(e);
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    #1 rst_n = 1'b1;
  endtask

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    tv[0] = '{8'h0F, 8'h01, 3'b000, 8'h10, 1'b0};
    tv[1] = '{8'h05, 8'h03, 3'b001, 8'h02, 1'b0};
    tv[2] = '{8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0};
    tv[3] = '{8'hAA, 8'hFF, 3'b011, 8'h55, 1'b0};
    tv[4] = '{8'h0F, 8'h00, 3'b100, 8'hF0, 1'b0};
    tv[5] = '{8'h81, 8'h01, 3'b101, 8'h02, 1'b0};
    tv[6] = '{8'h81, 8'h01, 3'b111, 8'h00, 1'b1};
    tv[7] = '{8'h80, 8'h03, 3'b110, 8'h10, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.req_func  = 3'b000;
    bus.rsp_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_operands", {13'd0, bus.alu_a, bus.alu_b, bus.alu_func}, 32'd0);
    chk("rst_rsp", {23'd0, bus.rsp_c, bus.rsp_err}, 32'd0);

    // Latency: accepted at E0, rsp_valid after E2.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    send(8'h0F, 8'h01, 3'b000, 8'h10, 1'b0);
    @(negedge clk);
    chk("lat_e0_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_e0_count", 32'(bus.fifo_count), 32'd1);
    @(negedge clk);
    chk("lat_e1_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_e1_count", 32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    chk("lat_e2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("lat_e2_rsp_c", 32'(bus.rsp_c), 32'h10);
    @(posedge clk); #1;
    drain();

    // Table-driven single operations.
    for (int i = 0; i < 8; i++) begin
      send(tv[i].a, tv[i].b, tv[i].f, tv[i].c, tv[i].err);
      drain();
    end

    // Back-to-back fill with the consumer stalled.
    repeat (3) @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(8'h05, 8'h03, 3'b001, 8'h02, 1'b0);
    send(8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0);
    send(8'hAA, 8'hFF, 3'b011, 8'h55, 1'b0);
    send(8'h0F, 8'h00, 3'b100, 8'hF0, 1'b0);
    @(negedge clk);
    chk("fill_count3", 32'(bus.fifo_count), 32'd3);
    chk("fill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("fill_req_ready3", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    send(8'h01, 8'h01, 3'b000, 8'h02, 1'b0);
    @(negedge clk);
    chk("full_count4", 32'(bus.fifo_count), 32'd4);
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_a     = 8'h77;
    bus.req_b     = 8'h11;
    bus.req_func  = 3'b000;
    repeat (2) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("full_hold_count", 32'(bus.fifo_count), 32'd4);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    last_cyc = -1;
    gap_en = 1'b1;
    bus.rsp_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1 gap_en = 1'b0;

    // Reset while in RESP with two entries queued.
    bus.rsp_ready = 1'b0;
    send(8'h21, 8'h01, 3'b000, 8'h22, 1'b0);
    send(8'h33, 8'h03, 3'b001, 8'h30, 1'b0);
    send(8'h44, 8'h0F, 3'b010, 8'h04, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_operands", {13'd0, bus.alu_a, bus.alu_b, bus.alu_func}, 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("no_stale_rsp", 32'(seen), 32'd0);

    // Simultaneous push and pop with two entries stored.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(8'h10, 8'h20, 3'b000, 8'h30, 1'b0);
    send(8'h50, 8'h10, 3'b001, 8'h40, 1'b0);
    send(8'h0C, 8'h0A, 3'b011, 8'h06, 1'b0);
    @(negedge clk);
    chk("pp_pre_count", 32'(bus.fifo_count), 32'd2);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    send(8'h03, 8'h02, 3'b101, 8'h0C, 1'b0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("pp_count", 32'(bus.fifo_count), 32'd2);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drain();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, meaning the number of request FIFO entries; only the value 4 is required.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports req_a and req_b, input, 8 bits each: the operands.
REQ-007 The block SHALL have port req_func, input, 3 bits: the ALU opcode (000 add, 001 sub, 010 and, 011 xor, 100 not a, 101 shl, 110 shr, 111 illegal).
REQ-008 The block SHALL have ports alu_a and alu_b, output, 8 bits each: the operands driven to the external ALU.
REQ-009 The block SHALL have port alu_func, output, 3 bits: the opcode driven to the external ALU.
REQ-010 The block SHALL have port alu_c, input, 8 bits: the combinational result returned by the external ALU.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port rsp_c, output, 8 bits: the captured result.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the presented result came from opcode 111.
REQ-015 The block SHALL have port fifo_count, output, 3 bits: the number of occupied FIFO entries, 0 to 4.

Function
REQ-016 Requests SHALL be pushed into a 4-entry FIFO holding {a, b, func} on each edge where req_valid && req_ready.
REQ-017 The block SHALL drive req_ready = (fifo_count < 4) combinationally; it does not depend on req_valid.
REQ-018 The control FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-019 In IDLE with fifo_count > 0, the block SHALL pop the FIFO head into the operand registers and move to ISSUE on the next edge.
REQ-020 In IDLE with fifo_count == 0, the block SHALL remain in IDLE.
REQ-021 alu_a, alu_b and alu_func SHALL be driven directly from the operand registers.
REQ-022 The operand registers SHALL hold their last values outside ISSUE.
REQ-023 In ISSUE, the edge SHALL capture alu_c into rsp_c, set rsp_err = (operand func == 3'b111), and move to RESP; ISSUE always lasts exactly one cycle.
REQ-024 rsp_valid SHALL equal (state == RESP).
REQ-025 rsp_c and rsp_err SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-026 In RESP with rsp_ready high and fifo_count > 0, the block SHALL pop the head into the operand registers and go to ISSUE on that edge.
REQ-027 In RESP with rsp_ready high and fifo_count == 0, the block SHALL go to IDLE.
REQ-028 In RESP with rsp_ready low, the block SHALL stay in RESP.
REQ-029 Latency: a request accepted at edge E0 into an empty FIFO while in IDLE SHALL produce rsp_valid high after edge E2; there is no bypass path around the FIFO.
REQ-030 Throughput: with rsp_ready held high, the block SHALL complete one operation every 2 cycles.
REQ-031 On an edge with both a push and a pop, fifo_count SHALL be unchanged and ordering SHALL be preserved.
REQ-032 A push while fifo_count == 4 SHALL NOT occur, since req_ready is low.
REQ-033 FIFO read and write pointers SHALL be 2 bits and wrap from 3 to 0.
REQ-034 Results SHALL be returned in request order.
REQ-035 The block SHALL NOT modify alu_c; all arithmetic, including 8-bit truncation, belongs to the external ALU.

Reset
REQ-036 When rst_n is low at an edge, the block SHALL set: state to IDLE, FIFO pointers and fifo_count to 0, operand registers (alu_a, alu_b, alu_func) to 0, rsp_c to 0, rsp_err to 0, rsp_valid to 0.
REQ-037 A reset in any state, including mid-ISSUE or RESP, SHALL discard all queued and in-flight operations.
REQ-038 After a reset edge, req_ready SHALL be 1 whenever rst_n is high.

Verification
REQ-039 The bench SHALL cover: single add a=8'h0F, b=8'h01, func=000 accepted at E0 -> rsp_valid after E2, rsp_c=8'h10, rsp_err=0.
REQ-040 The bench SHALL cover: four back-to-back requests (sub 5-3, and F0&3C, xor AA^FF, not 0F) with rsp_ready low -> fifo_count reaches 3 with one op held in RESP, req_ready stays 1 until the FIFO is full; then release rsp_ready -> results 02, 30, 55, F0 in order, 2 cycles apart.
REQ-041 The bench SHALL cover: a fifth request while full (fifo_count==4, req_valid=1) -> req_ready=0, no push, and fifo_count unchanged.
REQ-042 The bench SHALL cover: shl a=8'h81, b=1 -> rsp_c=8'h02; then func=111 -> rsp_c=8'h00, rsp_err=1.
REQ-043 The bench SHALL cover: rst_n low for one edge while in RESP with 2 entries queued -> rsp_valid=0, fifo_count=0, alu_a/alu_b/alu_func=0, and no stale result appears afterwards.
REQ-044 The bench SHALL cover: a push and a pop on the same edge with fifo_count=2 -> fifo_count stays 2 and the next result matches the oldest entry.
